// File: rtl/cnt_event_stamp_pkg.sv
// Shared types for the event timestamping stage: capture FSM states,
// default counter/event widths, and the {evt, cnt} record layout at
// those default widths.
package cnt_event_stamp_pkg;

  localparam int CW_DEF = 32;
  localparam int EW_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  // Record at default widths; event mask sits above the timestamp.
  typedef struct packed {
    logic [EW_DEF-1:0] evt;
    logic [CW_DEF-1:0] cnt;
  } stamp_rec_t;

endpackage

// File: rtl/stamp_fifo.sv
// Generic synchronous FIFO, DEPTH entries of W bits, head shown combinationally.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: a push when full is ignored unless a pop frees the slot in the same cycle.
module stamp_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 36
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [W-1:0]               wr_dat_i,
  input  logic                       pop_i,
  output logic [W-1:0]               rd_dat_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]  wr_q;
  logic [AW:0]  rd_q;
  logic [W-1:0] mem_q [DEPTH];
  logic         push_ok;
  logic         pop_ok;

  // Extra pointer MSB distinguishes full from empty when the slot bits match.
  assign empty_o  = (wr_q == rd_q);
  assign full_o   = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign level_o  = wr_q - rd_q;
  assign rd_dat_o = mem_q[rd_q[AW-1:0]];
  assign pop_ok   = pop_i && !empty_o;
  assign push_ok  = push_i && (!full_o || pop_ok);

  // Pointer update; reset empties the FIFO in the same edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + PTR_ONE;
      if (pop_ok)  rd_q <= rd_q + PTR_ONE;
    end
  end

  // Storage write; contents past the pointers are never observed, so no reset.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= wr_dat_i;
  end

endmodule

// File: rtl/cnt_event_stamp.sv
// Captures {event mask, counter} records while armed and drains them via valid/ready.
// Latency: event in cycle N is presented at the output in cycle N+1 when the FIFO is empty.
// Backpressure: records are buffered up to DEPTH; further events are dropped and counted.
module cnt_event_stamp
  import cnt_event_stamp_pkg::*;
#(
  parameter int CW    = CW_DEF,
  parameter int EW    = EW_DEF,
  parameter int DEPTH = 8,
  parameter int DCW   = 16
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [CW-1:0]  cnt_i,
  input  logic [EW-1:0]  evt_i,
  input  logic           arm_i,
  input  logic           stop_i,
  output logic           out_valid_o,
  input  logic           out_ready_i,
  output logic [EW-1:0]  out_evt_o,
  output logic [CW-1:0]  out_cnt_o,
  output logic           busy_o,
  output logic           ovf_o,
  output logic [DCW-1:0] drop_cnt_o,
  output logic           wrap_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_ONE = (AW+1)'(1);

  typedef struct packed {
    logic [EW-1:0] evt;
    logic [CW-1:0] cnt;
  } rec_t;

  state_e         state_q, state_d;
  logic           ovf_q, ovf_d;
  logic [DCW-1:0] drop_q, drop_d;
  logic [CW-1:0]  prev_q;
  logic           prev_vld_q;

  rec_t           wr_rec;
  rec_t           head_rec;
  logic           fifo_full;
  logic           fifo_empty;
  logic [AW:0]    fifo_level;
  logic           capture;
  logic           pop;
  logic           push;
  logic           drop;
  logic           drain_done;
  logic           arm_start;

  assign capture    = (state_q == ST_ARMED) && (|evt_i);
  assign pop        = out_valid_o && out_ready_i;
  assign push       = capture && (!fifo_full || pop);
  assign drop       = capture && fifo_full && !pop;
  // FIFO is empty once this cycle's pop completes (no pushes happen in FLUSH).
  assign drain_done = fifo_empty || (pop && (fifo_level == LVL_ONE));
  assign arm_start  = (state_q == ST_IDLE) && arm_i;
  assign wr_rec     = '{evt: evt_i, cnt: cnt_i};

  stamp_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(rec_t))
  ) u_fifo (
    .clk_i    (CLK),
    .rst_i    (RST),
    .push_i   (push),
    .wr_dat_i (wr_rec),
    .pop_i    (pop),
    .rd_dat_o (head_rec),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .level_o  (fifo_level)
  );

  // Next state: arm only from IDLE, stop only from ARMED, FLUSH exits once drained.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (arm_i)      state_d = ST_ARMED;
      ST_ARMED: if (stop_i)     state_d = ST_FLUSH;
      ST_FLUSH: if (drain_done) state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  // Drop statistics: cleared when a new capture session starts, saturating count.
  always_comb begin
    ovf_d  = ovf_q;
    drop_d = drop_q;
    if (arm_start) begin
      ovf_d  = 1'b0;
      drop_d = '0;
    end else if (drop) begin
      ovf_d = 1'b1;
      if (drop_q != {DCW{1'b1}}) drop_d = drop_q + DCW'(1);
    end
  end

  // State and statistics registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

  // Previous counter sample for wrap detection; the valid bit masks the first cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
    end else begin
      prev_q     <= cnt_i;
      prev_vld_q <= 1'b1;
    end
  end

  // Head fields are forced to zero while nothing is queued so idle outputs are clean.
  assign out_valid_o = !fifo_empty;
  assign out_evt_o   = out_valid_o ? head_rec.evt : '0;
  assign out_cnt_o   = out_valid_o ? head_rec.cnt : '0;
  assign busy_o      = (state_q != ST_IDLE);
  assign ovf_o       = ovf_q;
  assign drop_cnt_o  = drop_q;
  assign wrap_o      = prev_vld_q && (cnt_i < prev_q);

endmodule

// File: tb/tb_cnt_event_stamp.sv
// Bench for cnt_event_stamp: scoreboard of expected records plus targeted scenario checks.
module tb_cnt_event_stamp;
  import cnt_event_stamp_pkg::*;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] cnt_i = '0;
  logic [3:0]  evt_i = '0;
  logic        arm_i = 1'b0;
  logic        stop_i = 1'b0;
  logic        out_ready_i = 1'b0;
  logic        out_valid_o;
  logic [3:0]  out_evt_o;
  logic [31:0] out_cnt_o;
  logic        busy_o;
  logic        ovf_o;
  logic [15:0] drop_cnt_o;
  logic        wrap_o;

  cnt_event_stamp #(.CW(32), .EW(4), .DEPTH(DEPTH), .DCW(16)) dut (
    .CLK         (clk),
    .RST         (RST),
    .cnt_i       (cnt_i),
    .evt_i       (evt_i),
    .arm_i       (arm_i),
    .stop_i      (stop_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_evt_o   (out_evt_o),
    .out_cnt_o   (out_cnt_o),
    .busy_o      (busy_o),
    .ovf_o       (ovf_o),
    .drop_cnt_o  (drop_cnt_o),
    .wrap_o      (wrap_o)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  stamp_rec_t  exp_q[$];
  int          m_state;
  logic        m_ovf;
  logic [15:0] m_drop;
  logic [31:0] m_prev;
  logic        m_prev_vld;
  logic [31:0] fc;
  logic        last_wrap;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reset the DUT and the reference model together.
  task automatic do_reset();
    RST = 1'b1; evt_i = '0; arm_i = 1'b0; stop_i = 1'b0; out_ready_i = 1'b0; cnt_i = '0;
    @(posedge clk); #1;
    RST = 1'b0;
    exp_q.delete();
    m_state = 0; m_ovf = 1'b0; m_drop = '0; m_prev = '0; m_prev_vld = 1'b0;
  endtask

  // One clock cycle: drive, check outputs against model, advance model.
  task automatic cycle(input logic [3:0] evt, input logic [31:0] cnt,
                       input logic arm, input logic stop, input logic rdy);
    bit full, pop, cap;
    stamp_rec_t r;
    evt_i = evt; cnt_i = cnt; arm_i = arm; stop_i = stop; out_ready_i = rdy;
    #1;
    check_eq("valid", out_valid_o, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      check_eq("rec_evt", out_evt_o, exp_q[0].evt);
      check_eq("rec_cnt", out_cnt_o, exp_q[0].cnt);
    end
    check_eq("busy", busy_o, m_state != 0);
    check_eq("ovf", ovf_o, m_ovf);
    check_eq("drop_cnt", drop_cnt_o, m_drop);
    check_eq("wrap", wrap_o, m_prev_vld && (cnt < m_prev));
    last_wrap = wrap_o;
    full = (exp_q.size() == DEPTH);
    pop  = (exp_q.size() != 0) && rdy;
    cap  = (m_state == 1) && (evt != 0);
    if (pop) exp_q.delete(0);
    if (cap) begin
      if (!full || pop) begin
        r.evt = evt; r.cnt = cnt;
        exp_q.push_back(r);
      end else begin
        m_ovf = 1'b1;
        if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
      end
    end
    case (m_state)
      0: if (arm) begin m_state = 1; m_ovf = 1'b0; m_drop = '0; end
      1: if (stop) m_state = 2;
      default: if (exp_q.size() == 0) m_state = 0;
    endcase
    m_prev = cnt; m_prev_vld = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic tick(input logic [3:0] evt, input logic arm, input logic stop, input logic rdy);
    cycle(evt, fc, arm, stop, rdy);
    fc = fc + 32'd1;
  endtask

  initial begin
    int n;
    fc = 32'd10;
    do_reset();
    // Reset state
    check_eq("rst_valid", out_valid_o, 1'b0);
    check_eq("rst_evt", out_evt_o, 4'd0);
    check_eq("rst_cnt", out_cnt_o, 32'd0);
    check_eq("rst_busy", busy_o, 1'b0);
    check_eq("rst_ovf", ovf_o, 1'b0);
    check_eq("rst_drop", drop_cnt_o, 16'd0);
    check_eq("rst_wrap", wrap_o, 1'b0);

    // Basic capture
    tick(4'd0, 1'b1, 1'b0, 1'b0);
    check_eq("arm_busy", busy_o, 1'b1);
    cycle(4'b0010, 32'd100, 1'b0, 1'b0, 1'b0);
    check_eq("cap_valid", out_valid_o, 1'b1);
    check_eq("cap_evt", out_evt_o, 4'd2);
    check_eq("cap_cnt", out_cnt_o, 32'd100);
    fc = 32'd200;
    tick(4'd0, 1'b0, 1'b0, 1'b1);
    check_eq("pop_valid", out_valid_o, 1'b0);

    // Overflow: ten events into eight slots
    for (int i = 0; i < 10; i++) tick(4'((i % 15) + 1), 1'b0, 1'b0, 1'b0);
    check_eq("ovf_flag", ovf_o, 1'b1);
    check_eq("ovf_drops", drop_cnt_o, 16'd2);
    tick(4'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) tick(4'd0, 1'b0, 1'b0, 1'b1);
    check_eq("flush_idle", busy_o, 1'b0);
    tick(4'd0, 1'b1, 1'b0, 1'b0);
    check_eq("rearm_ovf", ovf_o, 1'b0);
    check_eq("rearm_drops", drop_cnt_o, 16'd0);

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < DEPTH; i++) tick(4'(8 - (i % 8)), 1'b0, 1'b0, 1'b0);
    tick(4'b1001, 1'b0, 1'b0, 1'b1);
    check_eq("fullpp_drops", drop_cnt_o, 16'd0);
    check_eq("fullpp_ovf", ovf_o, 1'b0);
    tick(4'd0, 1'b0, 1'b1, 1'b0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid_o) begin
        tick(4'd0, 1'b0, 1'b0, 1'b1);
        n++;
      end
    end
    check_eq("fullpp_occupancy", n, 8);

    // Flush sequencing
    tick(4'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick(4'(1 << i), 1'b0, 1'b0, 1'b0);
    tick(4'd0, 1'b1, 1'b1, 1'b0);
    tick(4'hF, 1'b0, 1'b0, 1'b0);
    tick(4'hA, 1'b0, 1'b1, 1'b0);
    tick(4'd0, 1'b0, 1'b0, 1'b1);
    tick(4'd0, 1'b0, 1'b0, 1'b1);
    check_eq("flush_busy_hold", busy_o, 1'b1);
    tick(4'd0, 1'b0, 1'b0, 1'b1);
    check_eq("flush_busy_fall", busy_o, 1'b0);
    check_eq("flush_empty", out_valid_o, 1'b0);

    // Counter wrap
    cycle(4'd0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    cycle(4'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    check_eq("wrap_pre", last_wrap, 1'b0);
    cycle(4'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    check_eq("wrap_pulse", last_wrap, 1'b1);
    cycle(4'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    check_eq("wrap_hold", last_wrap, 1'b0);
    fc = 32'd1;

    // Reset in the middle of a drain
    tick(4'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tick(4'(i + 3), 1'b0, 1'b0, 1'b0);
    tick(4'd0, 1'b0, 1'b1, 1'b1);
    do_reset();
    check_eq("mid_rst_valid", out_valid_o, 1'b0);
    check_eq("mid_rst_busy", busy_o, 1'b0);
    check_eq("mid_rst_ovf", ovf_o, 1'b0);
    check_eq("mid_rst_drop", drop_cnt_o, 16'd0);
    check_eq("mid_rst_cnt", out_cnt_o, 32'd0);
    fc = 32'd50;
    tick(4'd0, 1'b0, 1'b0, 1'b1);
    tick(4'd0, 1'b0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
